// File: rtl/cm_topk_table.sv
// Top-K hot-address table fed by the count-min sketch: keeps the NUM_ENTRY highest
// estimated counts sorted descending and streams a frozen snapshot to the host on request.
module cm_topk_table #(
    parameter int NUM_ENTRY = 16,
    parameter int ADDR_SIZE = 22,
    parameter int CNT_SIZE  = 32,
    parameter int IDX_SIZE  = $clog2(NUM_ENTRY),
    parameter int DROP_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    input  logic [ADDR_SIZE-1:0] input_addr,
    input  logic [CNT_SIZE-1:0]  input_cnt,
    input  logic                 clear,
    input  logic                 readout_start,
    output logic                 readout_busy,
    output logic                 readout_valid,
    input  logic                 readout_ready,
    output logic [IDX_SIZE-1:0]  readout_idx,
    output logic [ADDR_SIZE-1:0] readout_addr,
    output logic [CNT_SIZE-1:0]  readout_cnt,
    output logic                 readout_last,
    output logic                 readout_done,
    output logic [IDX_SIZE:0]    num_valid,
    output logic [DROP_SIZE-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } rd_state_t;

    localparam logic [IDX_SIZE:0]    FULL_CNT = (IDX_SIZE+1)'(NUM_ENTRY);
    localparam logic [IDX_SIZE-1:0]  LAST_IDX = IDX_SIZE'(NUM_ENTRY - 1);
    localparam logic [DROP_SIZE-1:0] DROP_MAX = {DROP_SIZE{1'b1}};

    logic                 tab_valid_r [NUM_ENTRY];
    logic [ADDR_SIZE-1:0] tab_addr_r  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  tab_cnt_r   [NUM_ENTRY];
    logic [IDX_SIZE:0]    num_valid_r;
    logic [DROP_SIZE-1:0] drop_r;

    logic                 a_valid_r;
    logic [ADDR_SIZE-1:0] a_addr_r;
    logic [CNT_SIZE-1:0]  a_cnt_r;

    logic                 tab_valid_s [NUM_ENTRY];
    logic [ADDR_SIZE-1:0] tab_addr_s  [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  tab_cnt_s   [NUM_ENTRY];
    logic [IDX_SIZE:0]    num_valid_s;
    logic [DROP_SIZE-1:0] drop_s;

    logic                 hit_s;
    logic [IDX_SIZE-1:0]  hit_idx_s;
    logic [CNT_SIZE-1:0]  new_cnt_s;
    logic [IDX_SIZE:0]    pos_s;
    logic [IDX_SIZE-1:0]  hi_s;
    logic                 full_s;
    logic                 accept_s;

    rd_state_t            state_r;
    rd_state_t            state_s;
    logic [IDX_SIZE-1:0]  rd_idx_r;
    logic [IDX_SIZE:0]    snap_num_r;
    logic [ADDR_SIZE-1:0] snap_addr_r [NUM_ENTRY];
    logic [CNT_SIZE-1:0]  snap_cnt_r  [NUM_ENTRY];
    logic                 stream_s;

    // Stage B: locate the address, compute the sorted slot and the rejection decision.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            hit_idx_s = (tab_valid_r[i] && (tab_addr_r[i] == a_addr_r)) ? IDX_SIZE'(i) : hit_idx_s;
            hit_s     = hit_s | (tab_valid_r[i] && (tab_addr_r[i] == a_addr_r));
        end
        full_s    = (num_valid_r == FULL_CNT);
        new_cnt_s = (hit_s && (tab_cnt_r[hit_idx_s] > a_cnt_r)) ? tab_cnt_r[hit_idx_s] : a_cnt_r;
        // Entries ahead of the new slot: all with count >= new count, and above the hit itself.
        pos_s = '0;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            pos_s = pos_s + {{IDX_SIZE{1'b0}},
                             (tab_valid_r[i] && (tab_cnt_r[i] >= new_cnt_s) &&
                              (!hit_s || (i < int'(hit_idx_s))))};
        end
        hi_s     = hit_s ? hit_idx_s : LAST_IDX;
        accept_s = a_valid_r && (hit_s || !full_s || (a_cnt_r > tab_cnt_r[NUM_ENTRY-1]));
    end

    // Next table image: clear wins, otherwise insert at pos_s and shift pos_s..hi_s-1 down.
    always_comb begin
        for (int j = 0; j < NUM_ENTRY; j++) begin
            int prev;
            prev = (j > 0) ? j - 1 : 0;
            tab_valid_s[j] = tab_valid_r[j];
            tab_addr_s[j]  = tab_addr_r[j];
            tab_cnt_s[j]   = tab_cnt_r[j];
            if (clear) begin
                tab_valid_s[j] = 1'b0;
                tab_addr_s[j]  = '0;
                tab_cnt_s[j]   = '0;
            end else if (accept_s && (j == int'(pos_s))) begin
                tab_valid_s[j] = 1'b1;
                tab_addr_s[j]  = a_addr_r;
                tab_cnt_s[j]   = new_cnt_s;
            end else if (accept_s && (j > int'(pos_s)) && (j <= int'(hi_s))) begin
                tab_valid_s[j] = tab_valid_r[prev];
                tab_addr_s[j]  = tab_addr_r[prev];
                tab_cnt_s[j]   = tab_cnt_r[prev];
            end else begin
                tab_valid_s[j] = tab_valid_r[j];
            end
        end
        num_valid_s = num_valid_r;
        if (clear) begin
            num_valid_s = '0;
        end else if (accept_s && !hit_s && !full_s) begin
            num_valid_s = num_valid_r + (IDX_SIZE+1)'(1);
        end else begin
            num_valid_s = num_valid_r;
        end
        drop_s = drop_r;
        if (a_valid_r && !accept_s && !clear && (drop_r != DROP_MAX)) begin
            drop_s = drop_r + DROP_SIZE'(1);
        end else begin
            drop_s = drop_r;
        end
    end

    // Stage A capture plus table and drop counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_r   <= 1'b0;
            a_addr_r    <= '0;
            a_cnt_r     <= '0;
            num_valid_r <= '0;
            drop_r      <= '0;
            for (int j = 0; j < NUM_ENTRY; j++) begin
                tab_valid_r[j] <= 1'b0;
                tab_addr_r[j]  <= '0;
                tab_cnt_r[j]   <= '0;
            end
        end else begin
            a_valid_r   <= input_valid;
            a_addr_r    <= input_addr;
            a_cnt_r     <= input_cnt;
            num_valid_r <= num_valid_s;
            drop_r      <= drop_s;
            for (int j = 0; j < NUM_ENTRY; j++) begin
                tab_valid_r[j] <= tab_valid_s[j];
                tab_addr_r[j]  <= tab_addr_s[j];
                tab_cnt_r[j]   <= tab_cnt_s[j];
            end
        end
    end

    // Readout next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (readout_start) begin
                    state_s = (num_valid_r != '0) ? STREAM : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (readout_ready && readout_last) begin
                    state_s = DONE;
                end else begin
                    state_s = STREAM;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Readout state, stream index and the snapshot taken when a dump starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            rd_idx_r   <= '0;
            snap_num_r <= '0;
            for (int j = 0; j < NUM_ENTRY; j++) begin
                snap_addr_r[j] <= '0;
                snap_cnt_r[j]  <= '0;
            end
        end else begin
            state_r <= state_s;
            if (state_r == IDLE) begin
                rd_idx_r <= '0;
            end else if (stream_s && readout_ready) begin
                rd_idx_r <= rd_idx_r + IDX_SIZE'(1);
            end
            if ((state_r == IDLE) && readout_start) begin
                snap_num_r <= num_valid_r;
                for (int j = 0; j < NUM_ENTRY; j++) begin
                    snap_addr_r[j] <= tab_addr_r[j];
                    snap_cnt_r[j]  <= tab_cnt_r[j];
                end
            end
        end
    end

    assign stream_s      = (state_r == STREAM);
    assign readout_busy  = stream_s;
    assign readout_valid = stream_s;
    assign readout_done  = (state_r == DONE);
    assign readout_idx   = stream_s ? rd_idx_r : '0;
    assign readout_addr  = stream_s ? snap_addr_r[rd_idx_r] : '0;
    assign readout_cnt   = stream_s ? snap_cnt_r[rd_idx_r] : '0;
    assign readout_last  = stream_s && ({1'b0, rd_idx_r} == (snap_num_r - (IDX_SIZE+1)'(1)));
    assign num_valid     = num_valid_r;
    assign drop_cnt      = drop_r;

endmodule

// File: tb/tb_cm_topk_table.sv
// Directed bench for cm_topk_table (NUM_ENTRY=4): expected dump entries are queued as
// stimulus is applied and popped as the DUT streams them out.
module tb_cm_topk_table;

    localparam int NE = 4;
    localparam int AW = 22;
    localparam int CW = 32;
    localparam int IW = 2;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          input_valid = 1'b0;
    logic [AW-1:0] input_addr = '0;
    logic [CW-1:0] input_cnt = '0;
    logic          clear = 1'b0;
    logic          readout_start = 1'b0;
    logic          readout_busy;
    logic          readout_valid;
    logic          readout_ready = 1'b1;
    logic [IW-1:0] readout_idx;
    logic [AW-1:0] readout_addr;
    logic [CW-1:0] readout_cnt;
    logic          readout_last;
    logic          readout_done;
    logic [IW:0]   num_valid;
    logic [DW-1:0] drop_cnt;

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
        logic          last;
    } ent_t;

    ent_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;

    cm_topk_table #(.NUM_ENTRY(NE), .ADDR_SIZE(AW), .CNT_SIZE(CW), .DROP_SIZE(DW)) dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .input_addr(input_addr),
        .input_cnt(input_cnt), .clear(clear), .readout_start(readout_start),
        .readout_busy(readout_busy), .readout_valid(readout_valid), .readout_ready(readout_ready),
        .readout_idx(readout_idx), .readout_addr(readout_addr), .readout_cnt(readout_cnt),
        .readout_last(readout_last), .readout_done(readout_done), .num_valid(num_valid),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input int a, input int c);
        input_valid = 1'b1;
        input_addr  = AW'(a);
        input_cnt   = CW'(c);
        tick();
        input_valid = 1'b0;
    endtask

    task automatic settle();
        tick();
        tick();
    endtask

    task automatic pe(input int i, input int a, input int c, input bit l);
        ent_t e;
        e.idx  = IW'(i);
        e.addr = AW'(a);
        e.cnt  = CW'(c);
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        settle();
        check("clear_num_valid", num_valid, 0);
    endtask

    task automatic dump(input bit toggle, input bit inject, output int done_cyc);
        ent_t e;
        bit   done;
        int   cyc;
        done     = 1'b0;
        cyc      = 0;
        done_cyc = -1;
        readout_start = 1'b1;
        tick();
        readout_start = 1'b0;
        while (!done && cyc < 64) begin
            readout_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (inject) begin
                input_valid = (cyc == 1);
                input_addr  = 22'h11;
                input_cnt   = 32'd100;
                clear       = (cyc == 3);
            end
            if (readout_done) begin
                done     = 1'b1;
                done_cyc = cyc;
                check("done_busy", readout_busy, 0);
                check("done_valid", readout_valid, 0);
                check("done_queue_empty", exp_q.size(), 0);
            end else if (readout_valid) begin
                check("stream_busy", readout_busy, 1);
                if (exp_q.size() == 0) begin
                    check("extra_entry", readout_valid, 0);
                end else begin
                    e = exp_q[0];
                    check("rd_idx", readout_idx, e.idx);
                    check("rd_addr", readout_addr, e.addr);
                    check("rd_cnt", readout_cnt, e.cnt);
                    check("rd_last", readout_last, e.last);
                    if (readout_ready) void'(exp_q.pop_front());
                end
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        if (inject) begin
            input_valid = 1'b0;
            clear       = 1'b0;
        end
        readout_ready = 1'b1;
        check("dump_timeout", done, 1);
        exp_q.delete();
        tick();
        check("done_one_cycle", readout_done, 0);
    endtask

    initial begin
        int dc;
        #1 rst = 1'b1;
        #12;
        check("rst_num_valid", num_valid, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_valid", readout_valid, 0);
        check("rst_busy", readout_busy, 0);
        check("rst_done", readout_done, 0);
        check("rst_last", readout_last, 0);
        tick();
        rst = 1'b0;
        tick();

        // basic sort
        upd(16, 5); upd(32, 9); upd(48, 7);
        settle();
        check("t1_num_valid", num_valid, 3);
        pe(0, 32, 9, 0); pe(1, 48, 7, 0); pe(2, 16, 5, 1);
        dump(1'b0, 1'b0, dc);
        check("t1_done_cycle", dc, 3);

        // fill, drop on tie with tail, evict on strictly greater
        do_clear();
        upd(1, 10); upd(2, 20); upd(3, 30); upd(4, 40); upd(5, 10);
        settle();
        check("t2_num_valid", num_valid, 4);
        check("t2_drop", drop_cnt, 1);
        upd(6, 15);
        settle();
        check("t2_drop_after_evict", drop_cnt, 1);
        pe(0, 4, 40, 0); pe(1, 3, 30, 0); pe(2, 2, 20, 0); pe(3, 6, 15, 1);
        dump(1'b0, 1'b0, dc);

        // hit promotes; lower count keeps the max
        upd(6, 35);
        settle();
        pe(0, 4, 40, 0); pe(1, 6, 35, 0); pe(2, 3, 30, 0); pe(3, 2, 20, 1);
        dump(1'b0, 1'b0, dc);
        upd(6, 12);
        settle();
        check("t3_drop", drop_cnt, 1);
        pe(0, 4, 40, 0); pe(1, 6, 35, 0); pe(2, 3, 30, 0); pe(3, 2, 20, 1);
        dump(1'b0, 1'b0, dc);

        // tie keeps incumbent ahead
        do_clear();
        upd(4, 40); upd(3, 30); upd(7, 30);
        settle();
        pe(0, 4, 40, 0); pe(1, 3, 30, 0); pe(2, 7, 30, 1);
        dump(1'b0, 1'b0, dc);

        // back-to-back same address
        do_clear();
        upd(8, 1); upd(8, 2); upd(8, 3);
        settle();
        check("t5_num_valid", num_valid, 1);
        pe(0, 8, 3, 1);
        dump(1'b0, 1'b0, dc);

        // stalled stream with update and clear injected mid-dump
        upd(9, 50); upd(10, 20);
        settle();
        pe(0, 9, 50, 0); pe(1, 10, 20, 0); pe(2, 8, 3, 1);
        dump(1'b1, 1'b1, dc);
        check("t6_done_cycle", dc, 5);
        settle();
        check("t6_num_valid_after_clear", num_valid, 0);
        check("t6_drop_kept", drop_cnt, 1);

        // empty dump
        dump(1'b0, 1'b0, dc);
        check("t7_empty_done_cycle", dc, 0);

        // reset mid-stream
        upd(1, 5); upd(2, 6);
        settle();
        readout_start = 1'b1;
        tick();
        readout_start = 1'b0;
        check("t8_streaming", readout_valid, 1);
        rst = 1'b1;
        #1;
        check("t8_valid", readout_valid, 0);
        check("t8_busy", readout_busy, 0);
        check("t8_done", readout_done, 0);
        check("t8_addr", readout_addr, 0);
        check("t8_cnt", readout_cnt, 0);
        check("t8_idx", readout_idx, 0);
        check("t8_num_valid", num_valid, 0);
        check("t8_drop", drop_cnt, 0);
        tick();
        rst = 1'b0;
        tick();
        check("t8_no_done", readout_done, 0);
        tick();
        check("t8_idle", readout_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
